// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the register-bank subsystem:
//   - default register width and bank depth
//   - state encoding of the bus-read handshake FSM
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2
    } state_t;

endpackage

// File: rtl/bus_read_fsm.sv
// -----------------------------------------------------------------------------
// bus_read_fsm
// Request/grant handshake for one bus read of the register bank.
//   IDLE  --rd_req-->  REQ  --bus_gnt-->  DRIVE  -->  IDLE
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   rd_req, rd_sel      read request and register select (latched in IDLE)
//   bus_gnt             arbiter grant, only honoured in REQ
//   bus_req             request to the arbiter (registered)
//   bus_oe, rd_done     high for the single DRIVE cycle (registered)
//   busy                high in REQ and DRIVE (registered)
//   capture             grant accepted this cycle: top loads its output register
//   sel                 latched read select
// -----------------------------------------------------------------------------
module bus_read_fsm
    import reg_bank_pkg::*;
#(
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             bus_gnt,
    output logic             bus_req,
    output logic             bus_oe,
    output logic             rd_done,
    output logic             busy,
    output logic             capture,
    output logic [SEL_W-1:0] sel
);

    state_t state;
    state_t state_nxt;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and a latch is never inferred.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE:  if (rd_req) state_nxt = REQ;
            REQ: begin
                if (bus_gnt) begin
                    capture   = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are flopped from the next state so they are clean registers
    // that line up exactly with the state they describe.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            bus_req <= 1'b0;
            bus_oe  <= 1'b0;
            rd_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            if (state == IDLE && rd_req) sel <= rd_sel;
            bus_req <= (state_nxt == REQ);
            bus_oe  <= (state_nxt == DRIVE);
            rd_done <= (state_nxt == DRIVE);
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule

// File: rtl/reg_bank_bus.sv
// -----------------------------------------------------------------------------
// reg_bank_bus
// DEPTH x WIDTH register bank loaded from the data bus, with one handshaked,
// registered read port back onto an OR-bus (to_bus is zero when not driving).
// Optional feature macro: REG_BANK_INC_EN adds inc_en/inc_sel, an in-place
// increment of one register per cycle (a same-register write wins).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   wr_en, wr_sel         write strobe and target (out-of-range target dropped)
//   from_bus              write data
//   inc_en, inc_sel       increment strobe and target (REG_BANK_INC_EN only)
//   rd_req, rd_sel        read request and source register
//   bus_gnt               arbiter grant
//   bus_req               bus request to the arbiter
//   bus_oe, rd_done       one-cycle drive / completion pulse
//   to_bus                read data, zero outside the drive cycle
//   busy                  read in progress
// -----------------------------------------------------------------------------
module reg_bank_bus
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int SEL_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] from_bus,
`ifdef REG_BANK_INC_EN
    input  logic             inc_en,
    input  logic [SEL_W-1:0] inc_sel,
`endif
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    input  logic             bus_gnt,
    output logic             bus_req,
    output logic             bus_oe,
    output logic [WIDTH-1:0] to_bus,
    output logic             rd_done,
    output logic             busy
);

    logic [WIDTH-1:0] regs     [DEPTH];
    logic [WIDTH-1:0] regs_nxt [DEPTH];
    logic [WIDTH-1:0] cap_val;
    logic [WIDTH-1:0] out_q;
    logic             capture;
    logic [SEL_W-1:0] sel;

    bus_read_fsm #(.SEL_W(SEL_W)) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .bus_gnt (bus_gnt),
        .bus_req (bus_req),
        .bus_oe  (bus_oe),
        .rd_done (rd_done),
        .busy    (busy),
        .capture (capture),
        .sel     (sel)
    );

    // Next value of each register; a write overrides an increment of the same
    // register. Targets beyond DEPTH-1 match no index and are dropped.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            regs_nxt[i] = regs[i];
`ifdef REG_BANK_INC_EN
            if (inc_en && int'(inc_sel) == i) regs_nxt[i] = regs[i] + WIDTH'(1);
`endif
            if (wr_en && int'(wr_sel) == i) regs_nxt[i] = from_bus;
        end
    end

    // Capture from the next-state values so a write or increment landing on
    // the grant edge is forwarded. An out-of-range select reads as zero.
    always_comb begin
        cap_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(sel) == i) cap_val = regs_nxt[i];
        end
    end

    // NOTE: the register array is reset element by element; these are
    // architectural registers whose reset value is visible, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= regs_nxt[i];
        end
    end

    // Output register is loaded only on the grant edge and cleared on every
    // other edge, which keeps the OR-bus at zero outside the drive cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else if (capture) begin
            out_q <= cap_val;
        end else begin
            out_q <= '0;
        end
    end

    assign to_bus = out_q;

endmodule

// File: tb/tb_reg_bank_bus.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_bus
// Drives a DEPTH=4 and a DEPTH=3 instance from the same stimulus. Reads push
// the expected data for each instance into a queue; negedge monitors pop and
// compare whenever bus_oe is high and check the bus is quiet otherwise.
// -----------------------------------------------------------------------------
module tb_reg_bank_bus;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [15:0] from_bus;
    logic        rd_req;
    logic [1:0]  rd_sel;
    logic        bus_gnt;
`ifdef REG_BANK_INC_EN
    logic        inc_en;
    logic [1:0]  inc_sel;
`endif

    logic        bus_req4, bus_oe4, rd_done4, busy4;
    logic [15:0] to_bus4;
    logic        bus_req3, bus_oe3, rd_done3, busy3;
    logic [15:0] to_bus3;

    logic [15:0] exp4_q [$];
    logic [15:0] exp3_q [$];
    int          n_total  = 0;
    int          n_pass   = 0;
    int          pushed   = 0;
    int          done4    = 0;
    int          done3    = 0;

    always #5 clk = ~clk;

    reg_bank_bus #(.WIDTH(16), .DEPTH(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .from_bus (from_bus),
`ifdef REG_BANK_INC_EN
        .inc_en   (inc_en),
        .inc_sel  (inc_sel),
`endif
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .bus_gnt  (bus_gnt),
        .bus_req  (bus_req4),
        .bus_oe   (bus_oe4),
        .to_bus   (to_bus4),
        .rd_done  (rd_done4),
        .busy     (busy4)
    );

    reg_bank_bus #(.WIDTH(16), .DEPTH(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .from_bus (from_bus),
`ifdef REG_BANK_INC_EN
        .inc_en   (inc_en),
        .inc_sel  (inc_sel),
`endif
        .rd_req   (rd_req),
        .rd_sel   (rd_sel),
        .bus_gnt  (bus_gnt),
        .bus_req  (bus_req3),
        .bus_oe   (bus_oe3),
        .to_bus   (to_bus3),
        .rd_done  (rd_done3),
        .busy     (busy3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (bus_oe4) begin
            check("rd_done4_with_oe", rd_done4, 1);
            check("queue4_nonempty", exp4_q.size() != 0, 1);
            if (exp4_q.size() != 0) check("to_bus4", to_bus4, exp4_q.pop_front());
            done4++;
        end else begin
            check("to_bus4_quiet", to_bus4, 0);
            check("rd_done4_quiet", rd_done4, 0);
        end
        if (bus_oe3) begin
            check("rd_done3_with_oe", rd_done3, 1);
            check("queue3_nonempty", exp3_q.size() != 0, 1);
            if (exp3_q.size() != 0) check("to_bus3", to_bus3, exp3_q.pop_front());
            done3++;
        end else begin
            check("to_bus3_quiet", to_bus3, 0);
            check("rd_done3_quiet", rd_done3, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] sel, input logic [15:0] val);
        wr_en = 1'b1; wr_sel = sel; from_bus = val;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic expect_read(input logic [15:0] e4, input logic [15:0] e3);
        exp4_q.push_back(e4);
        exp3_q.push_back(e3);
        pushed++;
    endtask

    // Full read with grant raised in the wait_n-th REQ cycle.
    task automatic do_read(input logic [1:0] sel, input int wait_n,
                           input logic [15:0] e4, input logic [15:0] e3);
        expect_read(e4, e3);
        rd_req = 1'b1; rd_sel = sel;
        tick();
        rd_req = 1'b0;
        for (int k = 0; k < wait_n; k++) begin
            check("bus_req_wait", bus_req4, 1);
            check("busy_wait", busy4, 1);
            if (k == wait_n - 1) bus_gnt = 1'b1;
            tick();
        end
        bus_gnt = 1'b0;
        check("bus_req_drive", bus_req4, 0);
        check("bus_oe_drive", bus_oe4, 1);
        tick();
        check("bus_oe_after", bus_oe4, 0);
        check("busy_after", busy4, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] oe_pat;
        rst_n = 1'b1; wr_en = 1'b0; wr_sel = '0; from_bus = '0;
        rd_req = 1'b0; rd_sel = '0; bus_gnt = 1'b0;
`ifdef REG_BANK_INC_EN
        inc_en = 1'b0; inc_sel = '0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_bus_req", bus_req4, 0);
        check("rst_bus_oe", bus_oe4, 0);
        check("rst_to_bus", to_bus4, 0);
        check("rst_rd_done", rd_done4, 0);
        check("rst_busy", busy4, 0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a read: aborted, registers cleared.
        write(2'd2, 16'h1234);
        rd_req = 1'b1; rd_sel = 2'd2;
        tick();
        rd_req = 1'b0;
        check("midrd_bus_req", bus_req4, 1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrd_rst_bus_req", bus_req4, 0);
        check("midrd_rst_busy", busy4, 0);
        check("midrd_rst_bus_oe", bus_oe4, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_read(2'd2, 1, 16'h0000, 16'h0000);

        // Basic read with grant after 3 REQ cycles; R3 absent in DEPTH=3.
        write(2'd3, 16'hBEEF);
        do_read(2'd3, 3, 16'hBEEF, 16'h0000);

        // Write-through on the grant edge.
        write(2'd1, 16'h0001);
        expect_read(16'hA5A5, 16'hA5A5);
        rd_req = 1'b1; rd_sel = 2'd1;
        tick();
        rd_req = 1'b0;
        bus_gnt = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; from_bus = 16'hA5A5;
        tick();
        bus_gnt = 1'b0; wr_en = 1'b0;
        check("fwd_bus_oe", bus_oe4, 1);
        tick();
        do_read(2'd1, 1, 16'hA5A5, 16'hA5A5);

        // Request while in REQ is ignored.
        write(2'd2, 16'h2222);
        write(2'd0, 16'h0F0F);
        expect_read(16'h2222, 16'h2222);
        rd_req = 1'b1; rd_sel = 2'd2;
        tick();
        rd_sel = 2'd0;
        tick();
        rd_req = 1'b0;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("ign_bus_oe", bus_oe4, 1);
        tick();
        check("ign_bus_req_1", bus_req4, 0);
        tick();
        check("ign_bus_req_2", bus_req4, 0);
        check("ign_busy", busy4, 0);

        // Grant while idle is ignored.
        bus_gnt = 1'b1;
        tick();
        tick();
        check("idle_gnt_bus_oe", bus_oe4, 0);
        check("idle_gnt_bus_req", bus_req4, 0);
        bus_gnt = 1'b0;

        // Level request and grant: DRIVE, IDLE, REQ, DRIVE.
        expect_read(16'hBEEF, 16'h0000);
        expect_read(16'hBEEF, 16'h0000);
        oe_pat = 5'b10010;
        rd_req = 1'b1; rd_sel = 2'd3; bus_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("level_bus_oe", bus_oe4, oe_pat[k]);
        end
        rd_req = 1'b0; bus_gnt = 1'b0;
        tick();
        check("level_end_bus_oe", bus_oe4, 0);
        check("level_end_busy", busy4, 0);

        // Out-of-range select on DEPTH=3: write dropped, read returns zero.
        write(2'd3, 16'h7777);
        do_read(2'd3, 1, 16'h7777, 16'h0000);
        write(2'd0, 16'h0ABC);
        do_read(2'd0, 2, 16'h0ABC, 16'h0ABC);

`ifdef REG_BANK_INC_EN
        write(2'd0, 16'hFFFF);
        inc_en = 1'b1; inc_sel = 2'd0;
        tick();
        inc_en = 1'b0;
        do_read(2'd0, 1, 16'h0000, 16'h0000);
        wr_en = 1'b1; wr_sel = 2'd0; from_bus = 16'h0005;
        inc_en = 1'b1; inc_sel = 2'd0;
        tick();
        wr_en = 1'b0; inc_en = 1'b0;
        do_read(2'd0, 1, 16'h0005, 16'h0005);
        wr_en = 1'b1; wr_sel = 2'd1; from_bus = 16'h1111;
        inc_en = 1'b1; inc_sel = 2'd2;
        tick();
        wr_en = 1'b0; inc_en = 1'b0;
        do_read(2'd1, 1, 16'h1111, 16'h1111);
        do_read(2'd2, 1, 16'h2223, 16'h2223);
`endif

        repeat (2) tick();
        check("done4_count", done4, pushed);
        check("done3_count", done3, pushed);
        check("queue4_drained", exp4_q.size(), 0);
        check("queue3_drained", exp3_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/reg_bank_bus.md
# reg_bank_bus

Parametrised register bank with an arbitrated bus read port. Holds DEPTH registers of WIDTH bits loaded from the shared data bus, and drives one selected register back onto the bus via a request/grant handshake with the bus arbiter. Sits between the datapath bus and the bus arbiter in the register-bank subsystem, replacing fixed two-register selection with N registers and a registered, handshaked bus drive.

## Interface
- WIDTH, 16, register and bus width in bits (>=1)
- DEPTH, 4, number of registers (>=2)
- SEL_W, $clog2(DEPTH), select width (derived, not overridden)

- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- WR_EN  in  1  load FROM_BUS into register WR_SEL this cycle
- WR_SEL  in  SEL_W  write target
- FROM_BUS  in  WIDTH  write data
- RD_REQ  in  1  start a bus read of register RD_SEL (1-cycle pulse or level)
- RD_SEL  in  SEL_W  read source, sampled only when a request is accepted
- BUS_GNT  in  1  arbiter grant
- BUS_REQ  out  1  bus request to arbiter
- BUS_OE  out  1  TO_BUS valid/driven this cycle
- TO_BUS  out  WIDTH  read data; all-zero whenever BUS_OE=0 (OR-bus)
- RD_DONE  out  1  one-cycle pulse, coincident with BUS_OE
- BUSY  out  1  high in REQ and DRIVE

## Operation
- Reset (async assert, sync deassert by system): all registers 0, state IDLE, BUS_REQ=0, BUS_OE=0, TO_BUS=0, RD_DONE=0, BUSY=0. Reset mid-read aborts with no RD_DONE.
- Write: on rising edge with WR_EN=1 and WR_SEL<DEPTH, register WR_SEL <= FROM_BUS. WR_SEL>=DEPTH: write dropped. Writes proceed in every state.
- FSM states IDLE, REQ, DRIVE:
  - IDLE: RD_REQ=1 -> latch RD_SEL, go REQ.
  - REQ: BUS_REQ=1; BUS_GNT=1 sampled -> capture selected register into output register, go DRIVE; else stay.
  - DRIVE: BUS_OE=1, RD_DONE=1, TO_BUS=captured value; unconditionally -> IDLE.
- RD_REQ in REQ or DRIVE ignored (no queueing); a level RD_REQ held through DRIVE starts a new read from IDLE the following cycle.
- Capture forwarding: if WR_EN writes the latched register on the grant edge, the captured value is FROM_BUS (write-through).
- Latched select >= DEPTH: read completes normally, TO_BUS=0.
- BUS_GNT outside REQ ignored.

## Timing
- RD_REQ sampled at edge t -> BUS_REQ high from t+1.
- BUS_GNT sampled high at edge g -> BUS_REQ low, BUS_OE/RD_DONE/TO_BUS valid for exactly cycle g..g+1.
- Minimum read latency: request edge to data = 2 cycles (grant in first REQ cycle). Back-to-back reads: one IDLE cycle between DRIVE cycles.
- Write-to-read visibility: written value visible to any capture on a later edge; same-edge via forwarding.
- All outputs registered; no combinational input-to-output path.

## Configuration
- REG_BANK_INC_EN defined: adds ports INC_EN (in, 1) and INC_SEL (in, SEL_W); register INC_SEL <= itself + 1, modulo 2^WIDTH (all-ones wraps to 0). WR_EN to same register takes priority; increment and write to different registers both happen. Forwarding on grant edge also applies to the incremented value.
- Not defined: ports absent, registers change only by write or reset.

## Structure
- Package reg_bank_pkg: FSM state enum (IDLE, REQ, DRIVE), default WIDTH/DEPTH localparams.
- Sub-module bus_read_fsm: state register, BUS_REQ/BUS_OE/RD_DONE/BUSY generation, select latch; the top holds the register array, write/increment logic, capture mux and forwarding.

## Test plan
- Reset: load R2=0x1234, assert RST_N=0 mid-REQ -> all registers 0, BUS_REQ=0, no RD_DONE.
- Basic read: write R3=0xBEEF, RD_REQ RD_SEL=3, grant 3 cycles later -> BUS_REQ high 3 cycles, then one cycle BUS_OE=1, RD_DONE=1, TO_BUS=0xBEEF, then TO_BUS=0.
- Forwarding: read R1 (holds 0x0001), write R1=0xA5A5 on the grant edge -> TO_BUS=0xA5A5.
- Busy ignore: second RD_REQ RD_SEL=0 while in REQ -> only the first read completes, one RD_DONE.
- Out-of-range (DEPTH=3): write sel 3 dropped; read sel 3 -> RD_DONE with TO_BUS=0.
- REG_BANK_INC_EN: R0=0xFFFF, INC_SEL=0 one cycle -> R0=0x0000; simultaneous WR_EN R0=0x0005 and INC -> R0=0x0005.
